prescaler_ctrl: RTL and testbench

Configuration controller and arbiter for the two-stage clock prescaler. Two requesters, A and B, submit new stage divide values over a REQ/ACK handshake. A round-robin arbiter grants one request at a time. Granted values are applied only at a safe boundary (the OUT_CLK toggle point), so OUT_CLK never emits a runt phase. The block contains the two cascaded divide counters in the CLK domain and generates OUT_CLK plus a single-cycle TICK enable.

---
 rtl/prescaler_ctrl.sv | 135 +++++++++++++
 tb/tb_prescaler_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaler_ctrl.sv
// Two-stage clock prescaler with a round-robin config arbiter for two requesters.
// New divide values are applied only at an OUT_CLK toggle point (or while EN is low).
module prescaler_ctrl #(
  parameter int W        = 4,
  parameter int RST_DIV1 = 3,
  parameter int RST_DIV2 = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         A_REQ,
  input  logic [W-1:0] A_DIV1,
  input  logic [W-1:0] A_DIV2,
  output logic         A_ACK,
  input  logic         B_REQ,
  input  logic [W-1:0] B_DIV1,
  input  logic [W-1:0] B_DIV2,
  output logic         B_ACK,
  output logic         OUT_CLK,
  output logic         TICK,
  output logic         BUSY,
  output logic [W-1:0] CUR_DIV1,
  output logic [W-1:0] CUR_DIV2
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state, state_next;
  logic [W-1:0] cnt1, cnt2;
  logic [W-1:0] pend1, pend2;
  logic         owner_b;   // granted requester is B
  logic         ptr_b;     // round-robin pointer favours B on a tie
  logic         wrap1, wrap2, boundary, apply;
  logic         req_a, req_b, grant_a, grant_b;

  assign wrap1    = (cnt1 == CUR_DIV1);
  assign wrap2    = (cnt2 == CUR_DIV2);
  assign boundary = !EN || (wrap1 && wrap2);
  assign apply    = (state == HOLD) && boundary;

  // Masking with the ACK keeps a requester from being re-granted in its ACK cycle.
  assign req_a = A_REQ & ~A_ACK;
  assign req_b = B_REQ & ~B_ACK;

  assign BUSY = (state == HOLD);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || !ptr_b)) begin
          grant_a    = 1'b1;
          state_next = HOLD;
        end else if (req_b) begin
          grant_b    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (boundary) state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: pending registers are reset too; cheap here and keeps them free of X.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend1   <= '0;
      pend2   <= '0;
      owner_b <= 1'b0;
      ptr_b   <= 1'b0;
      A_ACK   <= 1'b0;
      B_ACK   <= 1'b0;
    end else begin
      if (grant_a) begin
        pend1   <= A_DIV1;
        pend2   <= A_DIV2;
        owner_b <= 1'b0;
        ptr_b   <= 1'b1;
      end else if (grant_b) begin
        pend1   <= B_DIV1;
        pend2   <= B_DIV2;
        owner_b <= 1'b1;
        ptr_b   <= 1'b0;
      end
      A_ACK <= apply && !owner_b;
      B_ACK <= apply &&  owner_b;
    end
  end

  // Cascaded divide counters; an applied config restarts both stages from zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt1     <= '0;
      cnt2     <= '0;
      OUT_CLK  <= 1'b0;
      TICK     <= 1'b0;
      CUR_DIV1 <= W'(RST_DIV1);
      CUR_DIV2 <= W'(RST_DIV2);
    end else if (apply) begin
      cnt1     <= '0;
      cnt2     <= '0;
      CUR_DIV1 <= pend1;
      CUR_DIV2 <= pend2;
      OUT_CLK  <= OUT_CLK ^ EN;
      TICK     <= EN;
    end else if (EN) begin
      TICK <= 1'b0;
      if (wrap1) begin
        cnt1 <= '0;
        if (wrap2) begin
          cnt2    <= '0;
          OUT_CLK <= ~OUT_CLK;
          TICK    <= 1'b1;
        end else begin
          cnt2 <= cnt2 + 1'b1;
        end
      end else begin
        cnt1 <= cnt1 + 1'b1;
      end
    end else begin
      TICK <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Testbench for prescaler_ctrl: scenario tasks plus randomized traffic, checked against
// a model that tracks the divided clock as one linear position within the half period.
module tb_prescaler_ctrl;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST, EN;
  logic         A_REQ, B_REQ, A_ACK, B_ACK;
  logic [W-1:0] A_DIV1, A_DIV2, B_DIV1, B_DIV2;
  logic         OUT_CLK, TICK, BUSY;
  logic [W-1:0] CUR_DIV1, CUR_DIV2;
  logic [12:0]  dut_vec;

  int checks   = 0;
  int failures = 0;

  prescaler_ctrl #(.W(W), .RST_DIV1(3), .RST_DIV2(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .A_REQ(A_REQ), .A_DIV1(A_DIV1), .A_DIV2(A_DIV2), .A_ACK(A_ACK),
    .B_REQ(B_REQ), .B_DIV1(B_DIV1), .B_DIV2(B_DIV2), .B_ACK(B_ACK),
    .OUT_CLK(OUT_CLK), .TICK(TICK), .BUSY(BUSY),
    .CUR_DIV1(CUR_DIV1), .CUR_DIV2(CUR_DIV2)
  );

  always #5 CLK = ~CLK;

  assign dut_vec = {OUT_CLK, TICK, BUSY, A_ACK, B_ACK, CUR_DIV1, CUR_DIV2};

  // Reference model: position within the half period instead of two cascaded counters.
  int m_pos, m_cur1, m_cur2, m_pend1, m_pend2;
  bit m_out, m_tick, m_hold, m_owner_b, m_ptr_b, m_ack_a, m_ack_b;
  bit a_drop, b_drop;

  function automatic void model_reset();
    m_pos = 0; m_cur1 = 3; m_cur2 = 1; m_pend1 = 0; m_pend2 = 0;
    m_out = 0; m_tick = 0; m_hold = 0; m_owner_b = 0; m_ptr_b = 0;
    m_ack_a = 0; m_ack_b = 0;
  endfunction

  function automatic void model_edge();
    int half    = (m_cur1 + 1) * (m_cur2 + 1);
    bit at_end  = EN && (m_pos == half - 1);
    bit ma      = A_REQ && !m_ack_a;
    bit mb      = B_REQ && !m_ack_b;
    bit n_ack_a = 0;
    bit n_ack_b = 0;
    if (m_hold && (!EN || at_end)) begin
      m_cur1 = m_pend1; m_cur2 = m_pend2; m_pos = 0;
      m_tick = EN;
      if (EN) m_out = !m_out;
      n_ack_a = !m_owner_b;
      n_ack_b = m_owner_b;
      m_hold  = 0;
    end else begin
      if (!EN)         m_tick = 0;
      else if (at_end) begin m_pos = 0; m_out = !m_out; m_tick = 1; end
      else             begin m_pos++; m_tick = 0; end
      if (!m_hold && (ma || mb)) begin
        m_owner_b = mb && (!ma || m_ptr_b);
        m_pend1   = m_owner_b ? int'(B_DIV1) : int'(A_DIV1);
        m_pend2   = m_owner_b ? int'(B_DIV2) : int'(A_DIV2);
        m_ptr_b   = !m_owner_b;
        m_hold    = 1;
      end
    end
    m_ack_a = n_ack_a;
    m_ack_b = n_ack_b;
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_out, m_tick, m_hold, m_ack_a, m_ack_b, W'(m_cur1), W'(m_cur2)};
  endfunction

  // Requester behaviour: drop REQ on the edge that ends its ACK.
  function automatic void agent();
    if (a_drop) begin A_REQ = 1'b0; a_drop = 1'b0; end
    else if (A_ACK) a_drop = 1'b1;
    if (b_drop) begin B_REQ = 1'b0; b_drop = 1'b0; end
    else if (B_ACK) b_drop = 1'b1;
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RST = 1'b1; EN = 1'b0; A_REQ = 1'b0; B_REQ = 1'b0;
    a_drop = 1'b0; b_drop = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; A_REQ = 1'b0; B_REQ = 1'b0;
    A_DIV1 = '0; A_DIV2 = '0; B_DIV1 = '0; B_DIV2 = '0;
    a_drop = 1'b0; b_drop = 1'b0;
    model_reset();
    #2;
    checks++;
    if (dut_vec !== 13'b0_0_0_0_0_0011_0001) begin
      failures++;
      $display("FAIL reset_state: dut=%h required=%h", dut_vec, 13'b0_0_0_0_0_0011_0001);
    end
  endtask

  task automatic test_default_divide();
    int first_rise = 0;
    int toggles    = 0;
    logic prev;
    apply_reset();
    EN = 1'b1;
    prev = OUT_CLK;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL default_divide cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (first_rise == 0 && OUT_CLK === 1'b1) first_rise = i;
      if (OUT_CLK !== prev) toggles++;
      prev = OUT_CLK;
    end
    checks++;
    if (first_rise != 8) begin
      failures++;
      $display("FAIL default_first_rise: edge=%0d required=8", first_rise);
    end
    checks++;
    if (toggles != 5) begin
      failures++;
      $display("FAIL default_toggles: got=%0d required=5", toggles);
    end
  endtask

  task automatic test_single_request();
    int ack_at  = 0;
    int toggles = 0;
    logic prev;
    apply_reset();
    EN = 1'b1;
    repeat (2) step();
    A_DIV1 = 4'd1; A_DIV2 = 4'd0; A_REQ = 1'b1;
    for (int i = 1; i <= 40 && ack_at == 0; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL single_request cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (A_ACK === 1'b1) ack_at = i;
      agent();
    end
    checks++;
    if (ack_at != 6) begin
      failures++;
      $display("FAIL single_ack_latency: got=%0d required=6", ack_at);
    end
    prev = OUT_CLK;
    for (int i = 0; i < 13; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL single_after cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (OUT_CLK !== prev) toggles++;
      prev = OUT_CLK;
      agent();
    end
    checks++;
    if (toggles != 6) begin
      failures++;
      $display("FAIL single_div2_toggles: got=%0d required=6", toggles);
    end
  endtask

  task automatic test_back_to_back();
    int ack_a_at = 0;
    int ack_b_at = 0;
    int first    = 0;
    apply_reset();
    EN = 1'b1;
    A_DIV1 = 4'd2; A_DIV2 = 4'd0; B_DIV1 = 4'd0; B_DIV2 = 4'd1;
    A_REQ = 1'b1; B_REQ = 1'b1;
    for (int i = 1; i <= 60 && ack_b_at == 0; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec() || (A_ACK && B_ACK)) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (A_ACK === 1'b1) ack_a_at = i;
      if (B_ACK === 1'b1) ack_b_at = i;
      agent();
    end
    checks++;
    if (ack_a_at != 8 || ack_b_at != 11) begin
      failures++;
      $display("FAIL b2b_ack_order: a_at=%0d b_at=%0d required a_at=8 b_at=11", ack_a_at, ack_b_at);
    end
    repeat (2) begin step(); agent(); end
    A_DIV1 = 4'd1; A_DIV2 = 4'd1; B_DIV1 = 4'd2; B_DIV2 = 4'd2;
    A_REQ = 1'b1; B_REQ = 1'b1;
    for (int i = 1; i <= 60 && first == 0; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_second cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (A_ACK === 1'b1) first = 1;
      else if (B_ACK === 1'b1) first = 2;
      agent();
    end
    checks++;
    if (first != 1) begin
      failures++;
      $display("FAIL b2b_pointer: first_ack=%0d required=1 (A)", first);
    end
  endtask

  task automatic test_en_low();
    int toggle_at = 0;
    logic prev;
    apply_reset();
    EN = 1'b0;
    B_DIV1 = 4'd5; B_DIV2 = 4'd2; B_REQ = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL en_low cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (i == 2) begin
        checks++;
        if ({B_ACK, CUR_DIV1, CUR_DIV2, OUT_CLK} !== {1'b1, 4'd5, 4'd2, 1'b0}) begin
          failures++;
          $display("FAIL en_low_apply: ack=%b cur=%0d/%0d out=%b required ack=1 cur=5/2 out=0",
                   B_ACK, CUR_DIV1, CUR_DIV2, OUT_CLK);
        end
      end
      agent();
    end
    EN = 1'b1;
    prev = OUT_CLK;
    for (int i = 1; i <= 40 && toggle_at == 0; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL en_resume cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (OUT_CLK !== prev) toggle_at = i;
    end
    checks++;
    if (toggle_at != 18) begin
      failures++;
      $display("FAIL en_resume_first_toggle: edge=%0d required=18", toggle_at);
    end
  endtask

  task automatic test_div_zero();
    bit seen = 0;
    logic prev;
    apply_reset();
    EN = 1'b1;
    A_DIV1 = 4'd0; A_DIV2 = 4'd0; A_REQ = 1'b1;
    for (int i = 1; i <= 40 && !seen; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL div_zero cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (A_ACK === 1'b1) seen = 1;
      agent();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL div_zero_ack: ack not seen within 40 cycles");
    end
    prev = OUT_CLK;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec() || TICK !== 1'b1 || OUT_CLK === prev) begin
        failures++;
        $display("FAIL div_zero_run cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      prev = OUT_CLK;
      agent();
    end
  endtask

  task automatic test_reset_in_hold();
    int first_rise = 0;
    apply_reset();
    EN = 1'b1;
    repeat (2) step();
    A_DIV1 = 4'd1; A_DIV2 = 4'd0; A_REQ = 1'b1;
    repeat (2) step();
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL hold_busy: got=%b required=1", BUSY);
    end
    #2 RST = 1'b1;
    A_REQ = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 13'b0_0_0_0_0_0011_0001) begin
      failures++;
      $display("FAIL reset_in_hold: dut=%h required=%h", dut_vec, 13'b0_0_0_0_0_0011_0001);
    end
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if ({A_ACK, B_ACK, BUSY} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold_noack: ack_a=%b ack_b=%b busy=%b required 000", A_ACK, B_ACK, BUSY);
      end
    end
    RST = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL after_reset cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (first_rise == 0 && OUT_CLK === 1'b1) first_rise = i;
    end
    checks++;
    if (first_rise != 8) begin
      failures++;
      $display("FAIL after_reset_first_rise: edge=%0d required=8", first_rise);
    end
  endtask

  task automatic test_random();
    int acks = 0;
    apply_reset();
    for (int i = 1; i <= 3000; i++) begin
      EN = ($urandom_range(0, 9) != 0);
      if (!A_REQ && !a_drop && $urandom_range(0, 19) == 0) begin
        A_DIV1 = 4'($urandom_range(0, 4));
        A_DIV2 = 4'($urandom_range(0, 3));
        A_REQ  = 1'b1;
      end
      if (!B_REQ && !b_drop && $urandom_range(0, 19) == 0) begin
        B_DIV1 = 4'($urandom_range(0, 4));
        B_DIV2 = 4'($urandom_range(0, 3));
        B_REQ  = 1'b1;
      end
      step();
      checks++;
      if (dut_vec !== exp_vec() || (A_ACK && B_ACK)) begin
        failures++;
        $display("FAIL random cycle %0d: dut=%h model=%h", i, dut_vec, exp_vec());
      end
      if (A_ACK === 1'b1 || B_ACK === 1'b1) acks++;
      agent();
    end
    checks++;
    if (acks == 0) begin
      failures++;
      $display("FAIL random_acks: acks=%0d over 3000 cycles, required >0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_default_divide();
    test_single_request();
    test_back_to_back();
    test_en_low();
    test_div_zero();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
